// File: rtl/stage_phv_buf_if.sv
// Bundles the PHV handshake, control-path AXI-Stream and counter outputs of stage_phv_buf.
// slave modport: the buffer's view (PHV/control inputs in, buffered PHV/control/counters out).
// master modport: the surrounding logic's view (drives upstream PHV, control beats and stage_ready_in).
interface stage_phv_buf_if #(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int PHV_LEN              = 1124
);
    logic [PHV_LEN-1:0]                 phv_in;
    logic                               phv_in_valid;
    logic                               stage_ready_out;
    logic [PHV_LEN-1:0]                 phv_out;
    logic                               phv_out_valid;
    logic                               stage_ready_in;

    logic [C_S_AXIS_DATA_WIDTH-1:0]     c_s_axis_tdata;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]    c_s_axis_tuser;
    logic [C_S_AXIS_DATA_WIDTH/8-1:0]   c_s_axis_tkeep;
    logic                               c_s_axis_tvalid;
    logic                               c_s_axis_tlast;

    logic [C_S_AXIS_DATA_WIDTH-1:0]     c_m_axis_tdata;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]    c_m_axis_tuser;
    logic [C_S_AXIS_DATA_WIDTH/8-1:0]   c_m_axis_tkeep;
    logic                               c_m_axis_tvalid;
    logic                               c_m_axis_tlast;

    logic [31:0]                        drop_cnt;
    logic [31:0]                        acc_cnt;

    modport slave (
        input  phv_in, phv_in_valid, stage_ready_in,
        input  c_s_axis_tdata, c_s_axis_tuser, c_s_axis_tkeep, c_s_axis_tvalid, c_s_axis_tlast,
        output stage_ready_out, phv_out, phv_out_valid,
        output c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tvalid, c_m_axis_tlast,
        output drop_cnt, acc_cnt
    );

    modport master (
        output phv_in, phv_in_valid, stage_ready_in,
        output c_s_axis_tdata, c_s_axis_tuser, c_s_axis_tkeep, c_s_axis_tvalid, c_s_axis_tlast,
        input  stage_ready_out, phv_out, phv_out_valid,
        input  c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tvalid, c_m_axis_tlast,
        input  drop_cnt, acc_cnt
    );
endinterface

// File: rtl/stage_phv_buf.sv
// Elastic DEPTH-entry first-word-fall-through PHV buffer between RMT stages.
// Ports: axis_clk, aresetn (async active-low), bus (stage_phv_buf_if.slave): PHV in/out with
// stage_ready handshake, daisy-chained control stream (1-cycle pass-through), drop/accept counters.
module stage_phv_buf #(
    parameter int          C_S_AXIS_DATA_WIDTH  = 512,
    parameter int          C_S_AXIS_TUSER_WIDTH = 128,
    parameter int          PHV_LEN              = 1124,
    parameter int          DEPTH                = 8,
    parameter int          ADDR_W               = 3,
    parameter logic [7:0]  BUF_ID               = 8'hE0
) (
    input  logic            axis_clk,
    input  logic            aresetn,
    stage_phv_buf_if.slave  bus
);
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_RESET = (ADDR_W+1)'(DEPTH-2);

    logic [PHV_LEN-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [ADDR_W:0]    count;
    logic [ADDR_W:0]    count_next;
    logic [ADDR_W:0]    af_thresh;
    logic               first_beat;
    logic               head_vld;
    logic               push;
    logic               pop;
    logic               drop;

    logic               cfg_hit;
    logic [ADDR_W:0]    cfg_val;
    logic               cfg_ok;
    logic               cfg_clr;

    always_comb begin
        head_vld = (count != '0);
        pop      = head_vld && bus.stage_ready_in;
        // A full buffer still accepts when the head leaves in the same cycle.
        push     = bus.phv_in_valid && ((count != DEPTH_C) || pop);
        drop     = bus.phv_in_valid && !push;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Configuration is only decoded from the first beat of a packet addressed to this buffer.
    always_comb begin
        cfg_hit = bus.c_s_axis_tvalid && first_beat && (bus.c_s_axis_tdata[7:0] == BUF_ID);
        cfg_val = bus.c_s_axis_tdata[8 +: ADDR_W+1];
        cfg_ok  = (cfg_val != '0) && (cfg_val <= DEPTH_C);
        cfg_clr = cfg_hit && bus.c_s_axis_tdata[31];
    end

    // Storage is not reset; phv_out is masked whenever the buffer is empty.
    always_ff @(posedge axis_clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.phv_in;
        end
    end

    assign bus.phv_out       = head_vld ? mem[rd_ptr] : '0;
    assign bus.phv_out_valid = head_vld;

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            count               <= '0;
            bus.stage_ready_out <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count               <= count_next;
            bus.stage_ready_out <= (count_next < af_thresh);
        end
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            af_thresh    <= AF_RESET;
            first_beat   <= 1'b1;
            bus.drop_cnt <= '0;
            bus.acc_cnt  <= '0;
        end else begin
            if (bus.c_s_axis_tvalid) first_beat <= bus.c_s_axis_tlast;
            if (cfg_hit && cfg_ok)   af_thresh  <= cfg_val;
            if (cfg_clr) begin
                bus.drop_cnt <= '0;
                bus.acc_cnt  <= '0;
            end else begin
                if (drop && (bus.drop_cnt != 32'hFFFF_FFFF)) bus.drop_cnt <= bus.drop_cnt + 1'b1;
                if (push)                                    bus.acc_cnt  <= bus.acc_cnt + 1'b1;
            end
        end
    end

    // Control beats are forwarded unconditionally, including the ones that configure this buffer.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            bus.c_m_axis_tdata  <= '0;
            bus.c_m_axis_tuser  <= '0;
            bus.c_m_axis_tkeep  <= '0;
            bus.c_m_axis_tvalid <= 1'b0;
            bus.c_m_axis_tlast  <= 1'b0;
        end else begin
            bus.c_m_axis_tdata  <= bus.c_s_axis_tdata;
            bus.c_m_axis_tuser  <= bus.c_s_axis_tuser;
            bus.c_m_axis_tkeep  <= bus.c_s_axis_tkeep;
            bus.c_m_axis_tvalid <= bus.c_s_axis_tvalid;
            bus.c_m_axis_tlast  <= bus.c_s_axis_tlast;
        end
    end
endmodule
